// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port main-memory arbiter (instruction cache vs data cache).
// Widths follow `XLEN / `BYTEENABLE_WIDTH; defaults apply when no system defines are loaded.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BYTEENABLE_WIDTH
`define BYTEENABLE_WIDTH 4
`endif

package mem_arbiter_pkg;

    localparam int XLEN_W = `XLEN;
    localparam int BE_W   = `BYTEENABLE_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } arb_port_t;

    typedef struct packed {
        logic [XLEN_W-1:0] address;
        logic [XLEN_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
        logic              read;
        logic              write;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_IDLE = '{
        address:    {XLEN_W{1'b0}},
        writedata:  {XLEN_W{1'b0}},
        byteenable: {BE_W{1'b0}},
        read:       1'b0,
        write:      1'b0
    };

    // Write beats read on one port; a read carries no write data to memory.
    function automatic mem_req_t make_req(
        input logic [XLEN_W-1:0] address,
        input logic [XLEN_W-1:0] writedata,
        input logic [BE_W-1:0]   byteenable,
        input logic              read,
        input logic              write
    );
        mem_req_t r;
        r.address    = address;
        r.byteenable = byteenable;
        r.write      = write;
        r.read       = read & ~write;
        r.writedata  = write ? writedata : {XLEN_W{1'b0}};
        return r;
    endfunction

endpackage

// File: rtl/mod_mem_arbiter_pick.sv
// Combinational winner selection between the two requesters.
// A tie goes to the port that did not win last; a fixed tie-off of PORT_INSTR gives data priority.
module mod_mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic      instr_req,
    input  logic      data_req,
    input  arb_port_t last_grant,
    output arb_port_t winner,
    output logic      any_req
);

    // Pick the winner from the request pair and the previous grant.
    always_comb begin
        any_req = instr_req | data_req;
        winner  = PORT_INSTR;
        if (instr_req && data_req) begin
            winner = (last_grant == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end else if (data_req) begin
            winner = PORT_DATA;
        end else begin
            winner = PORT_INSTR;
        end
    end

endmodule

// File: rtl/mod_mem_arbiter.sv
// Shares one main-memory port between instruction and data caches; one transaction in flight.
// Define MEM_ARBITER_RR_EN to alternate ties between ports instead of fixed data priority.
module mod_mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN_W-1:0] instr_address_i,
    input  logic [XLEN_W-1:0] instr_writedata_i,
    input  logic              instr_read_i,
    input  logic              instr_write_i,
    input  logic [BE_W-1:0]   instr_byteenable_i,
    output logic [XLEN_W-1:0] instr_readdata_o,
    output logic              instr_operation_stb_o,
    input  logic [XLEN_W-1:0] data_address_i,
    input  logic [XLEN_W-1:0] data_writedata_i,
    input  logic              data_read_i,
    input  logic              data_write_i,
    input  logic [BE_W-1:0]   data_byteenable_i,
    output logic [XLEN_W-1:0] data_readdata_o,
    output logic              data_operation_stb_o,
    input  logic [XLEN_W-1:0] memory_readdata_i,
    input  logic              memory_operation_stb_i,
    output logic [XLEN_W-1:0] memory_address_o,
    output logic [XLEN_W-1:0] memory_writedata_o,
    output logic              memory_read_o,
    output logic              memory_write_o,
    output logic [BE_W-1:0]   memory_byteenable_o,
    output logic              grant_o,
    output logic              busy_o
);

    arb_state_t state_r;
    arb_port_t  grant_r;
    mem_req_t   mem_r;

    logic       instr_req_s;
    logic       data_req_s;
    logic       granted_req_s;
    logic       any_req_s;
    arb_port_t  winner_s;
    arb_port_t  last_grant_s;
    mem_req_t   winner_req_s;

    assign instr_req_s = instr_read_i | instr_write_i;
    assign data_req_s  = data_read_i  | data_write_i;

`ifdef MEM_ARBITER_RR_EN
    arb_port_t last_grant_r;

    // Remember who won most recently so the next tie goes the other way.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_r <= PORT_DATA;
        end else if (state_r == IDLE && any_req_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = PORT_INSTR;
`endif

    mod_mem_arbiter_pick u_pick (
        .instr_req  (instr_req_s),
        .data_req   (data_req_s),
        .last_grant (last_grant_s),
        .winner     (winner_s),
        .any_req    (any_req_s)
    );

    // Form the memory request of whichever port is about to be granted.
    always_comb begin
        winner_req_s = MEM_REQ_IDLE;
        case (winner_s)
            PORT_DATA:  winner_req_s = make_req(data_address_i, data_writedata_i,
                                                data_byteenable_i, data_read_i, data_write_i);
            PORT_INSTR: winner_req_s = make_req(instr_address_i, instr_writedata_i,
                                                instr_byteenable_i, instr_read_i, instr_write_i);
            default:    winner_req_s = MEM_REQ_IDLE;
        endcase
    end

    assign granted_req_s = (grant_r == PORT_DATA) ? data_req_s : instr_req_s;

    // Arbitration FSM; memory stb takes precedence over a requester withdrawing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            grant_r <= PORT_INSTR;
            mem_r   <= MEM_REQ_IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r <= BUSY;
                        grant_r <= winner_s;
                        mem_r   <= winner_req_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (memory_operation_stb_i) begin
                        state_r <= IDLE;
                        grant_r <= PORT_INSTR;
                        mem_r   <= MEM_REQ_IDLE;
                    end else if (!granted_req_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                DRAIN: begin
                    if (memory_operation_stb_i) begin
                        state_r <= IDLE;
                        grant_r <= PORT_INSTR;
                        mem_r   <= MEM_REQ_IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= PORT_INSTR;
                    mem_r   <= MEM_REQ_IDLE;
                end
            endcase
        end
    end

    // Completion goes back only to the granted port, and only while it is still waiting.
    always_comb begin
        instr_operation_stb_o = 1'b0;
        data_operation_stb_o  = 1'b0;
        if (state_r == BUSY && memory_operation_stb_i) begin
            instr_operation_stb_o = (grant_r == PORT_INSTR);
            data_operation_stb_o  = (grant_r == PORT_DATA);
        end else begin
            instr_operation_stb_o = 1'b0;
            data_operation_stb_o  = 1'b0;
        end
    end

    assign instr_readdata_o    = memory_readdata_i;
    assign data_readdata_o     = memory_readdata_i;
    assign memory_address_o    = mem_r.address;
    assign memory_writedata_o  = mem_r.writedata;
    assign memory_byteenable_o = mem_r.byteenable;
    assign memory_read_o       = mem_r.read;
    assign memory_write_o      = mem_r.write;
    assign grant_o             = grant_r;
    assign busy_o              = (state_r != IDLE);

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Directed table-driven bench for mod_mem_arbiter (default build: fixed data priority).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BYTEENABLE_WIDTH
`define BYTEENABLE_WIDTH 4
`endif

module tb_mod_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_address, instr_writedata, instr_readdata;
    logic        instr_read, instr_write, instr_stb;
    logic [3:0]  instr_byteenable;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_read, data_write, data_stb;
    logic [3:0]  data_byteenable;
    logic [31:0] mem_readdata, mem_address, mem_writedata;
    logic        mem_stb, mem_read, mem_write;
    logic [3:0]  mem_byteenable;
    logic        grant, busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mod_mem_arbiter dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .instr_address_i        (instr_address),
        .instr_writedata_i      (instr_writedata),
        .instr_read_i           (instr_read),
        .instr_write_i          (instr_write),
        .instr_byteenable_i     (instr_byteenable),
        .instr_readdata_o       (instr_readdata),
        .instr_operation_stb_o  (instr_stb),
        .data_address_i         (data_address),
        .data_writedata_i       (data_writedata),
        .data_read_i            (data_read),
        .data_write_i           (data_write),
        .data_byteenable_i      (data_byteenable),
        .data_readdata_o        (data_readdata),
        .data_operation_stb_o   (data_stb),
        .memory_readdata_i      (mem_readdata),
        .memory_operation_stb_i (mem_stb),
        .memory_address_o       (mem_address),
        .memory_writedata_o     (mem_writedata),
        .memory_read_o          (mem_read),
        .memory_write_o         (mem_write),
        .memory_byteenable_o    (mem_byteenable),
        .grant_o                (grant),
        .busy_o                 (busy)
    );

    typedef struct {
        logic        rst;
        logic        ir, iw;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, dwd;
        logic [3:0]  dbe;
        logic        ms;
        logic [31:0] mrd;
        logic        er, ew;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        logic        eg, eb, eis, eds;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_v, input logic ir, input logic iw, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
        input logic [3:0] dbe, input logic ms, input logic [31:0] mrd,
        input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ewd,
        input logic [3:0] ebe, input logic eg, input logic eb, input logic eis, input logic eds
    );
        vec_t v;
        v.rst = rst_v; v.ir = ir; v.iw = iw; v.ia = ia;
        v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.dbe = dbe;
        v.ms = ms; v.mrd = mrd;
        v.er = er; v.ew = ew; v.ea = ea; v.ewd = ewd; v.ebe = ebe;
        v.eg = eg; v.eb = eb; v.eis = eis; v.eds = eds;
        return v;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        instr_read = v.ir; instr_write = v.iw; instr_address = v.ia;
        data_read = v.dr; data_write = v.dw; data_address = v.da;
        data_writedata = v.dwd; data_byteenable = v.dbe;
        mem_stb = v.ms; mem_readdata = v.mrd;
    endtask

    function automatic logic [71:0] outs();
        return {mem_read, mem_write, mem_address, mem_writedata, mem_byteenable,
                busy, instr_stb, data_stb};
    endfunction

    initial begin
        instr_writedata  = 32'hFFFF_0000;
        instr_byteenable = 4'hF;
        drive(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);

        //              rst  ir   iw   ia       dr   dw   da       dwd           dbe   ms   mrd            | er   ew   ea       ewd           ebe   eg   eb   eis  eds
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h100,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h100,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b1,1'b0,32'h100,32'h0,       4'hF,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h100,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b1,1'b0,32'h100,32'h0,       4'hF,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h100,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b1,32'hDEADBEEF,  1'b1,1'b0,32'h100,32'h0,       4'hF,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        // tie: data first, then instr after one idle cycle
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h010,1'b1,1'b0,32'h20,32'h99999999, 4'hF,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h010,1'b1,1'b0,32'h20,32'h99999999, 4'hF,1'b0,32'h0,         1'b1,1'b0,32'h20,32'h0,        4'hF,1'b1,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h010,1'b1,1'b0,32'h20,32'h99999999, 4'hF,1'b1,32'hCAFE0001,  1'b1,1'b0,32'h20,32'h0,        4'hF,1'b1,1'b1,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h010,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h010,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b1,32'h11112222,  1'b1,1'b0,32'h10,32'h0,        4'hF,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        // data write with partial byteenable
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b1,32'h40,32'h12345678, 4'h3,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b1,32'h40,32'h12345678, 4'h3,1'b0,32'h0,         1'b0,1'b1,32'h40,32'h12345678, 4'h3,1'b1,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b1,32'h40,32'h12345678, 4'h3,1'b1,32'h0,         1'b0,1'b1,32'h40,32'h12345678, 4'h3,1'b1,1'b1,1'b0,1'b1));
        // read and write together on one port: write wins
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b1,1'b1,32'h44,32'hA5A5A5A5, 4'hF,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b1,1'b1,32'h44,32'hA5A5A5A5, 4'hF,1'b1,32'h0,         1'b0,1'b1,32'h44,32'hA5A5A5A5, 4'hF,1'b1,1'b1,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        // abort: data withdraws, DRAIN swallows the stb, pending instr follows
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b1,1'b0,32'h80,32'h55,       4'hF,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h090,1'b1,1'b0,32'h80,32'h55,       4'hF,1'b0,32'h0,         1'b1,1'b0,32'h80,32'h0,        4'hF,1'b1,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h090,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b1,1'b0,32'h80,32'h0,        4'hF,1'b1,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h090,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b1,1'b0,32'h80,32'h0,        4'hF,1'b1,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h090,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b1,32'h77,        1'b1,1'b0,32'h80,32'h0,        4'hF,1'b1,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h090,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h090,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b1,1'b0,32'h90,32'h0,        4'hF,1'b0,1'b1,1'b0,1'b0));
        // drop together with stb: stb still forwarded
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b1,32'h0BADF00D,  1'b1,1'b0,32'h90,32'h0,        4'hF,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        // stray stb in IDLE is ignored
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b1,32'h5,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        // reset while BUSY, then a late memory stb
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b1,1'b0,32'hC0,32'h0,        4'hF,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,32'h000,1'b1,1'b0,32'hC0,32'h0,        4'hF,1'b0,32'h0,         1'b1,1'b0,32'hC0,32'h0,        4'hF,1'b1,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b1,32'h66,        1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,32'h0,         1'b0,1'b0,32'h00,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d_outputs", i), outs(),
                  {vecs[i].er, vecs[i].ew, vecs[i].ea, vecs[i].ewd, vecs[i].ebe,
                   vecs[i].eb, vecs[i].eis, vecs[i].eds});
            if (vecs[i].eb) begin
                check($sformatf("row%0d_grant", i), {71'd0, grant}, {71'd0, vecs[i].eg});
            end
            if (vecs[i].eis || vecs[i].eds) begin
                check($sformatf("row%0d_readdata", i),
                      {8'd0, instr_readdata, data_readdata},
                      {8'd0, vecs[i].mrd, vecs[i].mrd});
            end
        end

        // reset taken while in DRAIN
        @(negedge clk);
        drive(mk(1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'hD0,32'h0,4'hF,1'b0,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,1'b0,1'b0));
        @(negedge clk);
        data_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("drain_before_reset", {70'd0, busy, mem_read}, {70'd0, 1'b1, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        mem_stb = 1'b1;
        #1;
        check("drain_after_reset", outs(), 72'd0);
        @(negedge clk);
        mem_stb = 1'b0;

        // bounded wait for a grant, then complete it
        instr_read = 1'b1;
        instr_address = 32'h200;
        for (int k = 0; k < 8 && !busy; k++) @(negedge clk);
        #1;
        check("wait_grant", {71'd0, busy}, {71'd0, 1'b1});
        check("wait_grant_addr", {40'd0, mem_address}, {40'd0, 32'h200});
        mem_stb = 1'b1;
        mem_readdata = 32'h3C3C_A5A5;
        #1;
        check("wait_stb", {38'd0, instr_stb, data_stb, instr_readdata},
              {38'd0, 1'b1, 1'b0, 32'h3C3C_A5A5});
        @(negedge clk);
        mem_stb = 1'b0;
        instr_read = 1'b0;
        #1;
        check("wait_idle", outs(), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
